// File: rtl/prbs_pkg.sv
// Shared types and helpers for the 4-bit PRBS checker: FSM state encoding,
// the prev seed value, and the next-word prediction of the upstream LFSR.
package prbs_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] PRBS_SEED = 4'hF;

  function automatic logic [3:0] prbs_pred(input logic [3:0] prev);
    return {prev[2:0], prev[2] ^ prev[1]};
  endfunction

endpackage

// File: rtl/prbs_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment
// so a clear coinciding with an event always leaves zero.
module prbs_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising checker for a 4-bit LFSR stream with HUNT/SYNC/LOCKED
// lock tracking. Define PRBS_CHECKER_STATS_EN to build the word_count counter.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       in_data,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [31:0]      word_count
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(LOSS_CNT + 1);

  state_t            state_reg, state_next;
  logic [3:0]        prev_reg, prev_next;
  logic [GOOD_W-1:0] good_reg, good_next;
  logic [BAD_W-1:0]  bad_reg, bad_next;
  logic              match;
  logic              err_hit;
  logic              locked_next;

  // All-zero never matches, so a stuck-at-zero source cannot hold lock.
  assign match = in_valid && (in_data == prbs_pred(prev_reg)) && (in_data != 4'h0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= HUNT;
      prev_reg  <= PRBS_SEED;
      good_reg  <= '0;
      bad_reg   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state_reg <= state_next;
      prev_reg  <= prev_next;
      good_reg  <= good_next;
      bad_reg   <= bad_next;
      locked    <= locked_next;
      err_pulse <= err_hit;
    end
  end

  always_comb begin
    state_next = state_reg;
    prev_next  = prev_reg;
    good_next  = good_reg;
    bad_next   = bad_reg;
    if (in_valid) begin
      prev_next = in_data;
      case (state_reg)
        HUNT: begin
          state_next = SYNC;
          good_next  = '0;
        end
        SYNC: begin
          if (match) begin
            good_next = good_reg + GOOD_W'(1);
            if (good_next == GOOD_W'(LOCK_CNT)) begin
              state_next = LOCKED;
              bad_next   = '0;
            end
          end else begin
            good_next = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            bad_next = '0;
          end else begin
            bad_next = bad_reg + BAD_W'(1);
            if (bad_next == BAD_W'(LOSS_CNT)) begin
              state_next = HUNT;
            end
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  always_comb begin
    locked_next = (state_next == LOCKED);
    err_hit     = in_valid && (state_reg == LOCKED) && !match;
  end

  prbs_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_hit),
    .clr   (clr),
    .count (err_count)
  );

`ifdef PRBS_CHECKER_STATS_EN
  logic [31:0] word_count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_count_reg <= '0;
    end else if (clr) begin
      word_count_reg <= '0;
    end else if (in_valid && (state_reg == LOCKED)) begin
      word_count_reg <= word_count_reg + 32'd1;
    end
  end

  assign word_count = word_count_reg;
`else
  assign word_count = '0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: a behavioural model pushes expected
// outputs per driven word, popped and compared one cycle later.
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_data = 4'h0;
  logic        clr = 1'b0;
  logic        locked, err_pulse, locked2, err_pulse2;
  logic [15:0] err_count;
  logic [1:0]  err_count2;
  logic [31:0] word_count, word_count2;

  always #5 clk = ~clk;

  prbs_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr(clr),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .word_count(word_count)
  );

  prbs_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr(clr),
    .locked(locked2), .err_pulse(err_pulse2), .err_count(err_count2), .word_count(word_count2)
  );

  typedef struct {
    logic        l;
    logic        p;
    logic [15:0] e;
    logic [1:0]  e2;
    logic [31:0] w;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: 0 = hunt, 1 = sync, 2 = locked
  int          m_state;
  logic [3:0]  m_prev;
  int          m_good, m_bad, m_err, m_err2;
  logic        m_pulse;
  logic [31:0] m_words;

  function automatic logic [3:0] lfsr(input logic [3:0] x);
    return {x[2], x[1], x[0], x[2] ^ x[1]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_prev = 4'hF; m_good = 0; m_bad = 0;
    m_err = 0; m_err2 = 0; m_pulse = 1'b0; m_words = 32'd0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check({tag, ".locked"},  32'(locked),     32'd0);
    check({tag, ".pulse"},   32'(err_pulse),  32'd0);
    check({tag, ".err"},     32'(err_count),  32'd0);
    check({tag, ".err2"},    32'(err_count2), 32'd0);
    check({tag, ".words"},   word_count,      32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic step(input string tag, input logic v, input logic [3:0] d, input logic c);
    exp_t e;
    logic match;
    in_valid = v; in_data = d; clr = c;
    m_pulse = 1'b0;
    if (v) begin
      match = (d == lfsr(m_prev)) && (d != 4'h0);
      case (m_state)
        0: begin m_state = 1; m_good = 0; end
        1: begin
          if (match) begin
            m_good++;
            if (m_good == 4) begin m_state = 2; m_bad = 0; end
          end else m_good = 0;
        end
        default: begin
          m_words++;
          if (match) m_bad = 0;
          else begin
            m_pulse = 1'b1;
            if (m_err < 65535) m_err++;
            if (m_err2 < 3) m_err2++;
            m_bad++;
            if (m_bad == 3) m_state = 0;
          end
        end
      endcase
      m_prev = d;
    end
    if (c) begin m_err = 0; m_err2 = 0; m_words = 32'd0; end
    e.l = (m_state == 2); e.p = m_pulse; e.e = m_err[15:0]; e.e2 = m_err2[1:0];
`ifdef PRBS_CHECKER_STATS_EN
    e.w = m_words;
`else
    e.w = 32'd0;
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".locked"}, 32'(locked),     32'(e.l));
    check({tag, ".pulse"},  32'(err_pulse),  32'(e.p));
    check({tag, ".err"},    32'(err_count),  32'(e.e));
    check({tag, ".err2"},   32'(err_count2), 32'(e.e2));
    check({tag, ".words"},  word_count,      e.w);
    check({tag, ".lock2"},  32'(locked2),    32'(e.l));
  endtask

  task automatic send_lock_seq(input string tag, input int gap);
    logic [3:0] seq [5];
    seq = '{4'hF, 4'hE, 4'hC, 4'h9, 4'h2};
    for (int i = 0; i < 5; i++) begin
      step(tag, 1'b1, seq[i], 1'b0);
      if (i < 2) for (int j = 0; j < gap; j++) step({tag, ".idle"}, 1'b0, 4'h0, 1'b0);
    end
  endtask

  initial begin
    logic [3:0] w;
    model_reset();
    do_reset("rst0");

    send_lock_seq("lock", 0);
    check("lock.final", 32'(locked), 32'd1);
    check("lock.err",   32'(err_count), 32'd0);

    step("corrupt0", 1'b1, 4'h0, 1'b0);
    step("corruptB", 1'b1, 4'hB, 1'b0);
    step("corrupt7", 1'b1, 4'h7, 1'b0);
    check("corrupt.err",    32'(err_count), 32'd2);
    check("corrupt.locked", 32'(locked),    32'd1);

    do_reset("rst_mid");

    send_lock_seq("gap", 3);
    check("gap.locked", 32'(locked), 32'd1);

    step("clr_err", 1'b1, 4'h0, 1'b1);
    check("clr_err.err", 32'(err_count), 32'd0);
    step("post_clr9", 1'b1, 4'h9, 1'b0);
    step("post_clr2", 1'b1, 4'h2, 1'b0);

    for (int i = 0; i < 3; i++) step("zeros", 1'b1, 4'h0, 1'b0);
    check("zeros.err",    32'(err_count),  32'd4);
    check("zeros.err2",   32'(err_count2), 32'd3);
    check("zeros.locked", 32'(locked),     32'd0);

    send_lock_seq("relock", 0);
    for (int k = 0; k < 2; k++) begin
      w = lfsr(lfsr(m_prev));
      step("sat0", 1'b1, 4'h0, 1'b0);
      step("sat1", 1'b1, w, 1'b0);
      step("sat2", 1'b1, lfsr(w), 1'b0);
    end
    check("sat.err2", 32'(err_count2), 32'd3);

    for (int i = 0; i < 60; i++) begin
      logic v, c;
      logic [3:0] d;
      v = ($urandom_range(0, 3) != 0);
      d = (m_prev == 4'h0) ? 4'hE : lfsr(m_prev);
      if ($urandom_range(0, 7) == 0) d = 4'($urandom_range(0, 15));
      c = v && ($urandom_range(0, 15) == 0);
      step("rand", v, d, c);
    end

    in_valid = 1'b0;
    clr = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 4: consecutive matching words needed to declare lock.
REQ-002 SHALL have parameter LOSS_CNT, default 3: consecutive mismatching words in LOCKED that drop lock.
REQ-003 SHALL have parameter CNT_W, default 16: err_count width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-low.
REQ-006 in_valid  input  1  in_data is a valid word this cycle.
REQ-007 in_data  input  4  word from upstream 4-bit LFSR generator (x[n+1] = {x[2:0], x[2]^x[1]}).
REQ-008 clr  input  1  synchronous clear of statistics counters.
REQ-009 locked  output  1  high while FSM is in LOCKED.
REQ-010 err_pulse  output  1  one-cycle strobe per errored word checked in LOCKED.
REQ-011 err_count  output  CNT_W  saturating count of errored words.
REQ-012 word_count  output  32  words checked in LOCKED; see Configuration.

Function
REQ-013 SHALL hold prev, the last accepted word; prediction pred = {prev[2:0], prev[2]^prev[1]}.
REQ-014 Word matches iff in_valid, in_data == pred and in_data != 4'h0; all-zero is always a mismatch (stuck-at detection).
REQ-015 Cycles with in_valid low SHALL change no state, counter or output except clearing err_pulse.
REQ-016 Every accepted word SHALL load prev, in every state (self-synchronising).
REQ-017 FSM states: HUNT, SYNC, LOCKED.
REQ-018 HUNT: on accepted word, go SYNC with good_cnt = 0.
REQ-019 SYNC: match increments good_cnt; when it reaches LOCK_CNT go LOCKED with bad_cnt = 0; mismatch resets good_cnt to 0, stays SYNC.
REQ-020 LOCKED: match clears bad_cnt; mismatch asserts err_pulse, increments err_count and bad_cnt; when bad_cnt reaches LOSS_CNT go HUNT.
REQ-021 Mismatches outside LOCKED SHALL NOT touch err_count or err_pulse.
REQ-022 All outputs registered; locked and err_pulse valid the cycle after the accepting edge.
REQ-023 err_count SHALL saturate at all ones, with no wrap-around.
REQ-024 clr SHALL zero err_count and word_count next edge without affecting the FSM; clr with a simultaneous error SHALL leave err_count = 0.
REQ-025 A single corrupted word in LOCKED yields exactly two errors (corrupt word plus next word); this is the required behaviour.

Reset
REQ-026 rst low SHALL immediately force state HUNT, prev = 4'hF, good_cnt = bad_cnt = 0, locked = 0, err_pulse = 0, err_count = 0, word_count = 0.
REQ-027 Reset mid-LOCKED SHALL discard lock; re-lock needs a full HUNT/SYNC sequence.

Configuration
REQ-028 Macro PRBS_CHECKER_STATS_EN defined: word_count increments, wrapping modulo 2^32, on every accepted word in LOCKED, match or not.
REQ-029 Macro undefined: word_count SHALL be constant 0, with no counter logic synthesised; port still present.

Structure
REQ-030 Package prbs_pkg SHALL hold the state typedef, seed constant 4'hF and the prediction function.
REQ-031 Sub-module prbs_sat_counter (parameterised width, inc, clr, saturation) SHALL implement err_count.

Verification
REQ-032 F,E,C,9,2 on consecutive valid cycles after reset -> locked = 1 after 5th word, err_count = 0.
REQ-033 Locked; send 0 in place of 5, then B,7 -> err_pulse on 2 words, err_count = 2, locked stays 1.
REQ-034 Locked; three consecutive 4'h0 -> err_count +3, locked = 0, FSM in HUNT.
REQ-035 F,E,C with in_valid low 3 cycles between each, then 9,2 -> identical lock to REQ-032.
REQ-036 Locked, err_count = 2; rst low for 1 cycle -> locked = 0, err_count = 0 asynchronously.
REQ-037 Locked; clr in the same cycle as a mismatch -> err_count = 0; with CNT_W = 2, 5 errors -> err_count = 3.
